// File: rtl/rs_enc_pkg.sv
// Shared constants and types for the RS(15,11) encoder over GF(16), primitive polynomial x^4+x+1.
// Generator g(x) = (x+a)(x+a^2)(x+a^3)(x+a^4) = x^4 + 13x^3 + 12x^2 + 8x + 7.
package rs_enc_pkg;

    localparam int GF16_W  = 4;
    localparam int RS_N    = 15;
    localparam int RS_K    = 11;
    localparam int RS_NPAR = RS_N - RS_K;
    localparam int CNT_W   = 4;

    // Low bits of x^4 after reduction: x^4 = x + 1
    localparam logic [GF16_W-1:0] GF16_POLY_LO = 4'b0011;

    localparam logic [GF16_W-1:0] G0 = 4'd7;
    localparam logic [GF16_W-1:0] G1 = 4'd8;
    localparam logic [GF16_W-1:0] G2 = 4'd12;
    localparam logic [GF16_W-1:0] G3 = 4'd13;
    localparam logic [GF16_W-1:0] G_COEF [RS_NPAR] = '{G0, G1, G2, G3};

    localparam logic [CNT_W-1:0] CNT_LAST_DATA = CNT_W'(RS_K - 1);
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(RS_N - 1);

    typedef enum logic [0:0] {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } rs_state_t;

endpackage

// File: rtl/gf16mul.sv
// Combinational GF(16) multiplier, polynomial basis, field polynomial x^4+x+1.
module gf16mul
    import rs_enc_pkg::*;
(
    input  logic [GF16_W-1:0] a,
    input  logic [GF16_W-1:0] b,
    output logic [GF16_W-1:0] p
);

    logic [GF16_W-1:0] shifted;

    // Shift-and-add: shifted holds a*x^i reduced mod the field polynomial
    always_comb begin
        shifted = a;
        p       = '0;
        for (int i = 0; i < GF16_W; i++) begin
            if (b[i]) begin
                p = p ^ shifted;
            end
            shifted = {shifted[GF16_W-2:0], 1'b0} ^ (shifted[GF16_W-1] ? GF16_POLY_LO : '0);
        end
    end

endmodule

// File: rtl/rs_enc_lfsr.sv
// Parity LFSR for RS(15,11): divides the message by g(x) while feeding, then shifts the
// remainder out highest-degree first on r3.
module rs_enc_lfsr
    import rs_enc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic              feed_en,
    input  logic [GF16_W-1:0] din,
    input  logic              clr,
    output logic [GF16_W-1:0] r3
);

    logic [GF16_W-1:0] r_reg [RS_NPAR];
    logic [GF16_W-1:0] prod  [RS_NPAR];
    logic [GF16_W-1:0] fb;

    assign fb = din ^ r_reg[RS_NPAR-1];
    assign r3 = r_reg[RS_NPAR-1];

    genvar gi;
    generate
        for (gi = 0; gi < RS_NPAR; gi++) begin : g_tap
            gf16mul u_mul (
                .a (fb),
                .b (G_COEF[gi]),
                .p (prod[gi])
            );
        end
    endgenerate

    // Shifting in zeros empties the register as the parity drains, so the next codeword
    // starts from a clean state without an explicit clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_NPAR; i++) r_reg[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < RS_NPAR; i++) r_reg[i] <= '0;
        end else if (feed_en) begin
            r_reg[0] <= prod[0];
            for (int i = 1; i < RS_NPAR; i++) r_reg[i] <= r_reg[i-1] ^ prod[i];
        end else if (shift_en) begin
            r_reg[0] <= '0;
            for (int i = 1; i < RS_NPAR; i++) r_reg[i] <= r_reg[i-1];
        end
    end

endmodule

// File: rtl/rs_enc_ctrl.sv
// RS(15,11) encoder controller: passes 11 message symbols through, then emits p3..p0.
// Optional RS_ENC_CTRL_ABORT_EN adds s_abort, which discards the codeword in progress.
module rs_enc_ctrl
    import rs_enc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
`ifdef RS_ENC_CTRL_ABORT_EN
    input  logic              s_abort,
`endif
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [GF16_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [GF16_W-1:0] m_data,
    output logic              m_sop,
    output logic              m_eop
);

    rs_state_t         state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              armed_reg;
    logic              m_valid_reg, m_sop_reg, m_eop_reg;
    logic [GF16_W-1:0] m_data_reg;

    logic              out_free, data_xfer, par_xfer, abort_hit;
    logic              lfsr_feed, lfsr_shift, lfsr_clr;
    logic [GF16_W-1:0] r3;

    rs_enc_lfsr u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (lfsr_shift),
        .feed_en  (lfsr_feed),
        .din      (s_data),
        .clr      (lfsr_clr),
        .r3       (r3)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        out_free   = !m_valid_reg || m_ready;
        s_ready    = (state_reg == ST_DATA) && out_free && armed_reg;
        data_xfer  = s_valid && s_ready;
        par_xfer   = (state_reg == ST_PARITY) && out_free;
`ifdef RS_ENC_CTRL_ABORT_EN
        // Symbol 0 arriving with abort starts a fresh codeword anyway, so let it through.
        abort_hit  = s_abort && !(data_xfer && (cnt_reg == '0));
`else
        abort_hit  = 1'b0;
`endif
        lfsr_feed  = data_xfer && !abort_hit;
        lfsr_shift = par_xfer && !abort_hit;
        lfsr_clr   = abort_hit;

        if (abort_hit) begin
            state_next = ST_DATA;
            cnt_next   = '0;
        end else if (lfsr_feed) begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_LAST_DATA) begin
                state_next = ST_PARITY;
            end
        end else if (lfsr_shift) begin
            if (cnt_reg == CNT_LAST) begin
                cnt_next   = '0;
                state_next = ST_DATA;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_DATA;
            cnt_reg   <= '0;
            armed_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            armed_reg <= 1'b1;
        end
    end

    // Single output stage; holds its contents while the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_sop_reg   <= 1'b0;
            m_eop_reg   <= 1'b0;
        end else if (abort_hit) begin
            m_valid_reg <= 1'b0;
            m_sop_reg   <= 1'b0;
            m_eop_reg   <= 1'b0;
        end else if (lfsr_feed) begin
            m_valid_reg <= 1'b1;
            m_data_reg  <= s_data;
            m_sop_reg   <= (cnt_reg == '0);
            m_eop_reg   <= 1'b0;
        end else if (lfsr_shift) begin
            m_valid_reg <= 1'b1;
            m_data_reg  <= r3;
            m_sop_reg   <= 1'b0;
            m_eop_reg   <= (cnt_reg == CNT_LAST);
        end else if (out_free) begin
            m_valid_reg <= 1'b0;
        end
    end

    assign m_valid = m_valid_reg;
    assign m_data  = m_data_reg;
    assign m_sop   = m_sop_reg;
    assign m_eop   = m_eop_reg;

endmodule

// File: doc/rs_enc_ctrl.md
Name: rs_enc_ctrl

Overview:
- Sequencing controller and parity engine for the systematic RS(15,11) encoder over GF(16), primitive polynomial x^4+x+1.
- Accepts 11 message symbols per codeword on a valid/ready input stream and passes them through unchanged.
- Then emits the 4 parity symbols computed by an LFSR built from constant GF(16) multipliers.
- Sits between the symbol source and the channel/interleaver stage; owns the codeword counter, phase FSM and output handshake.

Parameters:
- SYM_W, 4, symbol width in bits; fixed by GF(16), not overridable in practice.
- RS_N, 15, codeword length in symbols.
- RS_K, 11, message length in symbols; parity count RS_N-RS_K = 4.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input symbol valid.
- s_ready  out  1  block can accept an input symbol this cycle.
- s_data  in  4  message symbol, highest-degree coefficient first.
- m_valid  out  1  output symbol valid.
- m_ready  in  1  downstream accepts the output symbol.
- m_data  out  4  codeword symbol: 11 message symbols, then p3,p2,p1,p0.
- m_sop  out  1  marks codeword symbol 0.
- m_eop  out  1  marks codeword symbol 14.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - m_valid=0, m_data=0, m_sop=0, m_eop=0, s_ready=0 during reset.
  - LFSR r0..r3=0, sym_cnt=0, FSM=DATA.
  - s_ready goes to 1 in the first cycle after deassert.
- Output register: single stage; load allowed when m_valid=0 or m_ready=1 ("out_free").
- FSM states:
  - DATA:
    - s_ready = out_free.
    - Input transfer (s_valid & s_ready):
      - m_data <= s_data, m_valid <= 1.
      - m_sop <= (sym_cnt==0).
      - Feedback fb = s_data ^ r3, then r3<=r2^fb*13, r2<=r1^fb*12, r1<=r0^fb*8, r0<=fb*7.
      - sym_cnt++.
    - When the transfer hits sym_cnt==10: go to PARITY, sym_cnt <= 11.
  - PARITY:
    - s_ready=0.
    - Each cycle out_free: m_data <= r3, m_valid <= 1, then shift r3<=r2, r2<=r1, r1<=r0, r0<=0; sym_cnt++.
    - m_eop <= (sym_cnt==14).
    - After the sym_cnt==14 load: LFSR already zero, sym_cnt <= 0, go to DATA.
- If out_free=0 and m_valid=1, the output holds m_valid, m_data, m_sop and m_eop stable until m_ready.
- If out_free=1 and nothing is loaded, m_valid <= 0.
- Latency: input symbol appears on m_data 1 cycle after its transfer.
- Throughput: 1 symbol/cycle with m_ready=1. Codeword occupies 15 output cycles; input is stalled for 4 cycles per codeword.
- Back-to-back codewords: the first data symbol of codeword n+1 may be accepted in the cycle after the p0 load. There are no bubbles beyond the 4 parity cycles.
- s_valid low in DATA: FSM, counter and LFSR hold; gaps within a codeword are legal.
- Reset mid-codeword: partial codeword is discarded, nothing flushed; next symbol starts a new codeword.
- GF arithmetic: XOR add; constant multiplies by generator coefficients g0=7, g1=8, g2=12, g3=13 (g(x)=(x+α)(x+α²)(x+α³)(x+α⁴)).

Optional Feature:
- Macro: RS_ENC_CTRL_ABORT_EN.
- When defined:
  - Extra input port s_abort (1 bit).
  - s_abort=1 in any cycle clears the LFSR and sym_cnt, forces DATA, and drops m_valid next cycle unless a DATA-phase transfer of symbol 0 occurs in the same cycle; abort wins over any other transfer.
  - A pending output held under backpressure is discarded.
- When undefined: no port; behaviour as above.

Decomposition:
- Package rs_enc_pkg:
  - GF16_W=4, RS_N, RS_K, RS_NPAR=4.
  - Generator coefficient constants G0..G3 (7,8,12,13).
  - FSM state enum {ST_DATA, ST_PARITY}.
- Sub-module rs_enc_lfsr:
  - Four existing gf16mul instances with constant b inputs, plus 4x4-bit register file.
  - Ports: clk, rst_n, shift_en, feed_en, din, clr; output r3.
- rs_enc_ctrl keeps FSM, counter, handshake and output register.

Test Plan:
- All-zero message, m_ready=1: 15 outputs all 0, m_sop on symbol 0, m_eop on symbol 14, s_ready low exactly 4 cycles.
- Message 0,...,0,1 (last symbol 1): parity output 13,12,8,7.
- Two back-to-back codewords: second codeword's message 1,0,...,0 (x^14), continuous s_valid. Check that no bubbles appear apart from the parity gap, and that the second parity matches the golden model (x^14 mod g); the first codeword's state must not leak into the second.
- Random m_ready at 50% and random s_valid gaps over 1000 codewords: scoreboard against the software RS(15,11) encoder. Require m_data stable while m_valid&!m_ready.
- rst_n pulsed after symbol 6 of a codeword: all outputs 0 during reset; next 11 symbols encode as a fresh codeword with correct parity.
- With RS_ENC_CTRL_ABORT_EN: s_abort at sym_cnt=12 during PARITY. The remaining parity is suppressed, m_valid=0 next cycle, and the following codeword encodes correctly.
